// File: rtl/mem_pipe_reg.sv
// mem_pipe_reg: EX->MEM pipeline boundary built from DEPTH register slices.
// Every slice holds a valid bit and the EX result bundle. The whole chain
// holds on stall, and an incoming op is replaced by a zeroed bubble on flush.
// Optional feature macro: MEM_PIPE_FWD_EN. When it is defined, the module
// builds the EX-stage forwarding comparators over all in-flight slices.
// When it is undefined, the forwarding outputs are tied to zero.
module mem_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              ValidE,
  input  logic [XLEN-1:0]   ALUResultE,
  input  logic [XLEN-1:0]   WriteDataE,
  input  logic [XLEN-1:0]   PCplus4E,
  input  logic [RD_W-1:0]   RdE,
  input  logic [CTRL_W-1:0] CtrlE,
  input  logic [RD_W-1:0]   Rs1E,
  input  logic [RD_W-1:0]   Rs2E,
  output logic              ValidM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCplus4M,
  output logic [RD_W-1:0]   RdM,
  output logic [CTRL_W-1:0] CtrlM,
  output logic              FwdAHit,
  output logic              FwdBHit,
  output logic [XLEN-1:0]   FwdAData,
  output logic [XLEN-1:0]   FwdBData
);

  if (DEPTH < 1 || DEPTH > 4) begin : gBadDepth
    $error("mem_pipe_reg: DEPTH must be in 1..4");
  end

  // Slice storage: index 0 is the youngest, index DEPTH-1 drives the M outputs.
  logic              sliceVld  [DEPTH];
  logic [XLEN-1:0]   sliceAlu  [DEPTH];
  logic [XLEN-1:0]   sliceWd   [DEPTH];
  logic [XLEN-1:0]   slicePc   [DEPTH];
  logic [RD_W-1:0]   sliceRd   [DEPTH];
  logic [CTRL_W-1:0] sliceCtrl [DEPTH];

  // A real op enters only when it is valid and not flushed. Otherwise the
  // slice receives a fully zeroed bubble, so it cannot cause a writeback.
  logic takeOp;
  assign takeOp = ValidE & ~flush;

  // Shift chain: reset clears everything, stall holds, otherwise advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        sliceVld[i]  <= 1'b0;
        sliceAlu[i]  <= '0;
        sliceWd[i]   <= '0;
        slicePc[i]   <= '0;
        sliceRd[i]   <= '0;
        sliceCtrl[i] <= '0;
      end
    end else if (!stall) begin
      sliceVld[0]  <= takeOp;
      sliceAlu[0]  <= takeOp ? ALUResultE : '0;
      sliceWd[0]   <= takeOp ? WriteDataE : '0;
      slicePc[0]   <= takeOp ? PCplus4E   : '0;
      sliceRd[0]   <= takeOp ? RdE        : '0;
      sliceCtrl[0] <= takeOp ? CtrlE      : '0;
      for (int i = 1; i < DEPTH; i++) begin
        sliceVld[i]  <= sliceVld[i-1];
        sliceAlu[i]  <= sliceAlu[i-1];
        sliceWd[i]   <= sliceWd[i-1];
        slicePc[i]   <= slicePc[i-1];
        sliceRd[i]   <= sliceRd[i-1];
        sliceCtrl[i] <= sliceCtrl[i-1];
      end
    end
  end

  assign ValidM     = sliceVld[DEPTH-1];
  assign ALUResultM = sliceAlu[DEPTH-1];
  assign WriteDataM = sliceWd[DEPTH-1];
  assign PCplus4M   = slicePc[DEPTH-1];
  assign RdM        = sliceRd[DEPTH-1];
  assign CtrlM      = sliceCtrl[DEPTH-1];

`ifdef MEM_PIPE_FWD_EN
  // A slice may forward only when it will actually write a nonzero register.
  function automatic logic eligible(input logic vld, input logic [CTRL_W-1:0] ctrl,
                                    input logic [RD_W-1:0] rd);
    return vld & ctrl[0] & (rd != '0);
  endfunction

  // Forwarding select: scan from the oldest slice to the youngest, so the
  // youngest matching slice is the one that wins.
  always_comb begin
    FwdAHit  = 1'b0;
    FwdAData = '0;
    FwdBHit  = 1'b0;
    FwdBData = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible(sliceVld[i], sliceCtrl[i], sliceRd[i]) && sliceRd[i] == Rs1E) begin
        FwdAHit  = 1'b1;
        FwdAData = sliceAlu[i];
      end
      if (eligible(sliceVld[i], sliceCtrl[i], sliceRd[i]) && sliceRd[i] == Rs2E) begin
        FwdBHit  = 1'b1;
        FwdBData = sliceAlu[i];
      end
    end
  end
`else
  // Forwarding is not built. The source-register ports remain but have no load.
  logic unusedRs;
  assign unusedRs = ^{Rs1E, Rs2E};
  assign FwdAHit  = 1'b0;
  assign FwdBHit  = 1'b0;
  assign FwdAData = '0;
  assign FwdBData = '0;
`endif

endmodule

// File: tb/tb_mem_pipe_reg.sv
// tb_mem_pipe_reg: directed scenarios plus randomized traffic for mem_pipe_reg
// at DEPTH=3. The bench checks the outputs against an op-level reference model.
module tb_mem_pipe_reg;
  localparam int DEPTH = 3;

  typedef struct packed {
    logic        v;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } op_t;

  logic clk = 1'b0;
  logic reset, stall, flush, validE;
  logic [31:0] aluE, wdE, pcE;
  logic [4:0] rdE, rs1E, rs2E;
  logic [3:0] ctrlE;
  logic validM, fwdAHit, fwdBHit;
  logic [31:0] aluM, wdM, pcM, fwdAData, fwdBData;
  logic [4:0] rdM;
  logic [3:0] ctrlM;

  int total = 0;
  int bad = 0;
  op_t inFlight [DEPTH];

  always #5 clk = ~clk;

  mem_pipe_reg #(.XLEN(32), .RD_W(5), .CTRL_W(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .ValidE(validE),
    .ALUResultE(aluE), .WriteDataE(wdE), .PCplus4E(pcE), .RdE(rdE), .CtrlE(ctrlE),
    .Rs1E(rs1E), .Rs2E(rs2E), .ValidM(validM), .ALUResultM(aluM),
    .WriteDataM(wdM), .PCplus4M(pcM), .RdM(rdM), .CtrlM(ctrlM),
    .FwdAHit(fwdAHit), .FwdBHit(fwdBHit), .FwdAData(fwdAData), .FwdBData(fwdBData)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference forwarding: the first eligible op found from the youngest end wins.
  task automatic refFwd(input logic [4:0] rs, output logic hit, output logic [31:0] data);
    hit = 1'b0;
    data = '0;
`ifdef MEM_PIPE_FWD_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && inFlight[i].v && inFlight[i].ctrl[0] && inFlight[i].rd != 0 && inFlight[i].rd == rs) begin
        hit = 1'b1;
        data = inFlight[i].alu;
      end
    end
`endif
  endtask

  // Advance the reference model and the clock by one edge, then compare all outputs.
  task automatic step();
    logic eh;
    logic [31:0] ed;
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) inFlight[i] = '0;
    end else if (!stall) begin
      for (int i = DEPTH - 1; i > 0; i--) inFlight[i] = inFlight[i-1];
      if (validE && !flush) inFlight[0] = '{1'b1, aluE, wdE, pcE, rdE, ctrlE};
      else inFlight[0] = '0;
    end
    #1;
    chk("validM", validM, inFlight[DEPTH-1].v);
    chk("aluM", aluM, inFlight[DEPTH-1].alu);
    chk("wdM", wdM, inFlight[DEPTH-1].wd);
    chk("pcM", pcM, inFlight[DEPTH-1].pc);
    chk("rdM", rdM, inFlight[DEPTH-1].rd);
    chk("ctrlM", ctrlM, inFlight[DEPTH-1].ctrl);
    refFwd(rs1E, eh, ed);
    chk("fwdAHit", fwdAHit, eh);
    chk("fwdAData", fwdAData, ed);
    refFwd(rs2E, eh, ed);
    chk("fwdBHit", fwdBHit, eh);
    chk("fwdBData", fwdBData, ed);
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                       input logic [3:0] ctrl);
    validE = v;
    aluE = alu;
    wdE = alu ^ 32'h5A5A_0000;
    pcE = alu + 32'd4;
    rdE = rd;
    ctrlE = ctrl;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) inFlight[i] = '0;
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    rs1E = 5'd3; rs2E = 5'd7;
    drive(1'b1, 32'hDEAD_BEEF, 5'd3, 4'hF);
    step();
    step();
    chk("rst_validM", validM, 1'b0);
    chk("rst_aluM", aluM, 32'h0);
    chk("rst_fwdAHit", fwdAHit, 1'b0);
    chk("rst_fwdBHit", fwdBHit, 1'b0);

    // The op appears exactly DEPTH edges after it is captured.
    reset = 1'b0;
    drive(1'b1, 32'h0000_1234, 5'd7, 4'b0001);
    step(); chk("lat_e1", validM, 1'b0);
    drive(1'b0, 32'h0, 5'd0, 4'h0);
    step(); chk("lat_e2", validM, 1'b0);
    step(); chk("lat_e3_vld", validM, 1'b1);
    chk("lat_e3_alu", aluM, 32'h0000_1234);
    chk("lat_e3_rd", rdM, 5'd7);
    step(); chk("lat_e4", validM, 1'b0);

    // Stall: the output op stays in place while the E inputs keep changing.
    drive(1'b1, 32'hAAAA_0001, 5'd9, 4'b0011);
    step();
    drive(1'b0, 32'h0, 5'd0, 4'h0);
    for (int i = 0; i < DEPTH - 1; i++) step();
    chk("stall_pre", aluM, 32'hAAAA_0001);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 5'($urandom_range(1, 31)), 4'($urandom));
      flush = 1'($urandom);
      step();
      chk("stall_hold", aluM, 32'hAAAA_0001);
    end
    stall = 1'b0; flush = 1'b0;
    drive(1'b1, 32'hBBBB_0002, 5'd4, 4'b0001);
    step();
    drive(1'b0, 32'h0, 5'd0, 4'h0);
    for (int i = 0; i < DEPTH - 1; i++) step();
    chk("stall_next", aluM, 32'hBBBB_0002);

    // Flush: a valid op becomes a zero bubble. Stall together with flush holds the chain.
    flush = 1'b1;
    drive(1'b1, 32'h0000_5555, 5'd5, 4'b0001);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 4'h0);
    for (int i = 0; i < DEPTH - 1; i++) step();
    chk("flush_vld", validM, 1'b0);
    chk("flush_rd", rdM, 5'd0);
    chk("flush_ctrl", ctrlM, 4'd0);
    drive(1'b1, 32'h0000_6666, 5'd6, 4'b0101);
    for (int i = 0; i < DEPTH; i++) begin
      step();
      drive(1'b0, 32'h0, 5'd0, 4'h0);
    end
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h0000_7777, 5'd8, 4'b0001);
    step();
    chk("flushstall_alu", aluM, 32'h0000_6666);
    chk("flushstall_rd", rdM, 5'd6);
    stall = 1'b0; flush = 1'b0;

    // Forwarding priority: the youngest eligible match wins.
    rs1E = 5'd3; rs2E = 5'd0;
    drive(1'b1, 32'h11, 5'd3, 4'b0001); step();
    drive(1'b1, 32'h22, 5'd3, 4'b0001); step();
`ifdef MEM_PIPE_FWD_EN
    chk("fwd_young_hit", fwdAHit, 1'b1);
    chk("fwd_young_data", fwdAData, 32'h22);
`else
    chk("fwd_off_hit", fwdAHit, 1'b0);
    chk("fwd_off_data", fwdAData, 32'h0);
`endif
    drive(1'b1, 32'h11, 5'd3, 4'b0001); step();
    drive(1'b1, 32'h22, 5'd3, 4'b1110); step();
`ifdef MEM_PIPE_FWD_EN
    chk("fwd_noregwr_data", fwdAData, 32'h11);
`else
    chk("fwd_off_data2", fwdAData, 32'h0);
`endif
    drive(1'b1, 32'h33, 5'd0, 4'b0001); step();
    chk("fwd_rs0_hit", fwdBHit, 1'b0);
    chk("fwd_rs0_data", fwdBData, 32'h0);

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 5) == 0);
      drive(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 7)), 4'($urandom));
      rs1E = 5'($urandom_range(0, 7));
      rs2E = 5'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
